// File: rtl/hypervisor_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hypervisor_ctrl_if : CPU-side bus bundle for the hypervisor trap controller.
// Revision: 1.0
// ----------------------------------------------------------------------------
interface hypervisor_ctrl_if;
  logic        hyper_cs;
  logic [7:0]  hyper_addr;
  logic [7:0]  hyper_io_data_i;
  logic [7:0]  hyper_data_o;
  logic        cpu_write;
  logic        cpu_sync;
  logic        ready;
  logic        hyper_force_cs;
  logic [15:0] cpu_addr;
  logic        hyper_mode;
  logic        map_enable_ext;
  logic [1:0]  mapper_reg_sel;
  logic [7:0]  mapper_reg;

  modport master (
    output hyper_cs, hyper_addr, hyper_io_data_i, cpu_write, cpu_sync, ready,
           cpu_addr, mapper_reg,
    input  hyper_data_o, hyper_force_cs, hyper_mode, map_enable_ext,
           mapper_reg_sel
  );

  modport slave (
    input  hyper_cs, hyper_addr, hyper_io_data_i, cpu_write, cpu_sync, ready,
           cpu_addr, mapper_reg,
    output hyper_data_o, hyper_force_cs, hyper_mode, map_enable_ext,
           mapper_reg_sel
  );
endinterface
`default_nettype wire

// File: rtl/hypervisor_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hypervisor_ctrl : 4510 hypervisor trap decode, register file and JMP injector.
// Optional trap counter at offset 0x20 enabled by HYPER_TRAP_COUNT_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
module hypervisor_ctrl #(
  parameter logic [7:0] VECTOR_HI = 8'h80
) (
  input  logic              clk,
  input  logic              reset,
  hypervisor_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    INJ_IDLE = 2'd0,
    INJ_LO   = 2'd1,
    INJ_HI   = 2'd2
  } inj_state_e;

  localparam logic [7:0] JMP_ABS_OPC = 8'h4C;
  localparam logic [5:0] EXIT_OFS    = 6'h3F;

  inj_state_e  inj_q, inj_d;
  logic        mode_q, mode_d;
  logic        pending_q, pending_d;
  logic [5:0]  trap_num_q, trap_num_d;
  logic [7:0]  trap_data_q, trap_data_d;
  logic [7:0]  scratch_q [16];
  logic [7:0]  scratch_d [16];
`ifdef HYPER_TRAP_COUNT_EN
  logic [7:0]  trap_cnt_q, trap_cnt_d;
`endif

  logic [5:0]  offset;
  logic        wr;
  logic        force_raw;
  logic [7:0]  inj_byte;
  logic [7:0]  rd_data;
  logic        unused_sig;

  assign offset = bus.hyper_addr[5:0];
  assign wr     = bus.hyper_cs & bus.cpu_write & bus.ready;

  // cpu_addr is carried for debug only; the window decode arrives via hyper_cs.
  assign unused_sig = ^{bus.cpu_addr, bus.hyper_addr[7:6]};

  always_ff @(posedge clk) begin
    if (reset) begin
      inj_q       <= INJ_IDLE;
      mode_q      <= 1'b0;
      pending_q   <= 1'b0;
      trap_num_q  <= 6'd0;
      trap_data_q <= 8'h00;
      for (int i = 0; i < 16; i++) begin
        scratch_q[i] <= 8'h00;
      end
`ifdef HYPER_TRAP_COUNT_EN
      trap_cnt_q  <= 8'h00;
`endif
    end else begin
      inj_q       <= inj_d;
      mode_q      <= mode_d;
      pending_q   <= pending_d;
      trap_num_q  <= trap_num_d;
      trap_data_q <= trap_data_d;
      for (int i = 0; i < 16; i++) begin
        scratch_q[i] <= scratch_d[i];
      end
`ifdef HYPER_TRAP_COUNT_EN
      trap_cnt_q  <= trap_cnt_d;
`endif
    end
  end

  always_comb begin
    inj_d       = inj_q;
    mode_d      = mode_q;
    pending_d   = pending_q;
    trap_num_d  = trap_num_q;
    trap_data_d = trap_data_q;
    for (int i = 0; i < 16; i++) begin
      scratch_d[i] = scratch_q[i];
    end
`ifdef HYPER_TRAP_COUNT_EN
    trap_cnt_d  = trap_cnt_q;
`endif

    if (bus.ready) begin
      unique case (inj_q)
        INJ_IDLE: begin
          if (pending_q && bus.cpu_sync) begin
            inj_d     = INJ_LO;
            pending_d = 1'b0;
          end
        end
        INJ_LO:   inj_d = INJ_HI;
        INJ_HI:   inj_d = INJ_IDLE;
        default:  inj_d = INJ_IDLE;
      endcase
    end

    // A trap raised in the same cycle an older one starts injecting must stay pending.
    if (wr) begin
      if (!mode_q) begin
        mode_d      = 1'b1;
        trap_num_d  = offset;
        trap_data_d = bus.hyper_io_data_i;
        pending_d   = 1'b1;
`ifdef HYPER_TRAP_COUNT_EN
        trap_cnt_d  = trap_cnt_q + 8'd1;
`endif
      end else if (offset[5:4] == 2'b01) begin
        scratch_d[offset[3:0]] = bus.hyper_io_data_i;
      end else if (offset == EXIT_OFS) begin
        mode_d = 1'b0;
      end
    end
  end

  always_comb begin
    force_raw = 1'b0;
    inj_byte  = JMP_ABS_OPC;
    unique case (inj_q)
      INJ_IDLE: begin
        force_raw = pending_q & bus.cpu_sync;
        inj_byte  = JMP_ABS_OPC;
      end
      INJ_LO: begin
        force_raw = 1'b1;
        inj_byte  = {trap_num_q, 2'b00};
      end
      INJ_HI: begin
        force_raw = 1'b1;
        inj_byte  = VECTOR_HI;
      end
      default: begin
        force_raw = 1'b0;
        inj_byte  = JMP_ABS_OPC;
      end
    endcase
  end

  always_comb begin
    rd_data = 8'h00;
    if (offset[5:2] == 4'b0000) begin
      rd_data = bus.mapper_reg;
    end else if (offset == 6'h04) begin
      rd_data = {2'b00, trap_num_q};
    end else if (offset == 6'h05) begin
      rd_data = trap_data_q;
    end else if (offset[5:4] == 2'b01) begin
      rd_data = scratch_q[offset[3:0]];
`ifdef HYPER_TRAP_COUNT_EN
    end else if (offset == 6'h20) begin
      rd_data = trap_cnt_q;
`endif
    end else if (offset == EXIT_OFS) begin
      rd_data = {7'b0, mode_q};
    end
  end

  // Reset drops the forced route immediately, even before the state register clears.
  assign bus.hyper_force_cs = force_raw & ~reset;
  assign bus.hyper_data_o   = bus.hyper_force_cs ? inj_byte : rd_data;
  assign bus.hyper_mode     = mode_q;
  assign bus.map_enable_ext = mode_q;
  assign bus.mapper_reg_sel = offset[1:0];

endmodule
`default_nettype wire

// File: tb/tb_hypervisor_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_hypervisor_ctrl : scoreboard bench for hypervisor_ctrl (reads and injection).
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_hypervisor_ctrl;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;
  logic rd_en;

  logic [7:0] rd_q [$];
  string      rd_name_q [$];
  logic [7:0] inj_q [$];

  hypervisor_ctrl_if bus ();

  hypervisor_ctrl #(.VECTOR_HI(8'h80)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: got event with empty scoreboard, expected none", name);
  endtask

  always @(negedge clk) begin
    if (rd_en) begin
      if (rd_q.size() == 0) fail_now("rd_underflow");
      else chk(rd_name_q.pop_front(), bus.hyper_data_o, rd_q.pop_front());
    end
    if (bus.hyper_force_cs) begin
      if (inj_q.size() == 0) fail_now("inj_underflow");
      else if (bus.ready) chk("inj_byte", bus.hyper_data_o, inj_q.pop_front());
      else chk("inj_hold", bus.hyper_data_o, inj_q[0]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    bus.hyper_cs        = 1'b1;
    bus.cpu_write       = 1'b1;
    bus.hyper_addr      = addr;
    bus.hyper_io_data_i = data;
    cyc();
    bus.hyper_cs  = 1'b0;
    bus.cpu_write = 1'b0;
  endtask

  task automatic rd(input string name, input logic [7:0] addr, input logic [7:0] exp);
    bus.hyper_cs   = 1'b1;
    bus.hyper_addr = addr;
    rd_q.push_back(exp);
    rd_name_q.push_back(name);
    rd_en = 1'b1;
    cyc();
    rd_en        = 1'b0;
    bus.hyper_cs = 1'b0;
  endtask

  task automatic inject(input logic [7:0] lo);
    inj_q.push_back(8'h4C);
    inj_q.push_back(lo);
    inj_q.push_back(8'h80);
    bus.cpu_sync = 1'b1;
    cyc();
    bus.cpu_sync = 1'b0;
    cyc();
    cyc();
    chk("force_after_inj", {7'b0, bus.hyper_force_cs}, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    tests_failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests_run = 0; tests_failed = 0; rd_en = 1'b0;
    reset = 1'b1;
    bus.hyper_cs = 1'b0; bus.cpu_write = 1'b0; bus.cpu_sync = 1'b0; bus.ready = 1'b1;
    bus.hyper_addr = 8'h40; bus.hyper_io_data_i = 8'h00;
    bus.cpu_addr = 16'hD640; bus.mapper_reg = 8'h00;
    repeat (14) cyc();
    chk("rst_mode",  {7'b0, bus.hyper_mode},     8'h00);
    chk("rst_map",   {7'b0, bus.map_enable_ext}, 8'h00);
    chk("rst_force", {7'b0, bus.hyper_force_cs}, 8'h00);
    reset = 1'b0;
    rd("rst_trapnum", 8'h44, 8'h00);

    // Basic trap from user mode and its injected JMP $8000+4*3.
    wr(8'h43, 8'h5A);
    chk("trap_mode", {7'b0, bus.hyper_mode},     8'h01);
    chk("trap_map",  {7'b0, bus.map_enable_ext}, 8'h01);
    chk("trap_noforce", {7'b0, bus.hyper_force_cs}, 8'h00);
    rd("trap_num",  8'h44, 8'h03);
    rd("trap_data", 8'h45, 8'h5A);
    rd("scratch3_untouched", 8'h53, 8'h00);
    inject(8'h0C);

    // Same trap with ready stalls inside the injection.
    wr(8'h7F, 8'h00);
    chk("exit_mode", {7'b0, bus.hyper_mode}, 8'h00);
    wr(8'h43, 8'h5A);
    inj_q.push_back(8'h4C); inj_q.push_back(8'h0C); inj_q.push_back(8'h80);
    bus.cpu_sync = 1'b1; bus.ready = 1'b1; cyc();
    bus.cpu_sync = 1'b0; bus.ready = 1'b0; cyc();
    bus.ready = 1'b1; cyc();
    bus.ready = 1'b0; cyc();
    bus.ready = 1'b1; cyc();
    chk("stall_force_done", {7'b0, bus.hyper_force_cs}, 8'h00);

    // Scratch access in hyper mode, exit, and a trapping write to scratch.
    wr(8'h52, 8'hA5);
    rd("scratch2_rw", 8'h52, 8'hA5);
    wr(8'h7F, 8'hFF);
    chk("exit2_mode", {7'b0, bus.hyper_mode},     8'h00);
    chk("exit2_map",  {7'b0, bus.map_enable_ext}, 8'h00);
    rd("exit_reg_user", 8'h7F, 8'h00);
    wr(8'h52, 8'h33);
    rd("trap12_num",  8'h44, 8'h12);
    rd("trap12_data", 8'h45, 8'h33);
    rd("scratch2_kept", 8'h52, 8'hA5);
    inject(8'h48);
    rd("exit_reg_hyper", 8'h7F, 8'h01);

    // Ignored hyper write, mapper read-back, and accesses without hyper_cs.
    wr(8'h44, 8'hEE);
    rd("trapnum_ro", 8'h44, 8'h12);
    bus.mapper_reg = 8'h77;
    bus.hyper_addr = 8'h42;
    #1;
    chk("mapper_sel", {6'b0, bus.mapper_reg_sel}, 8'h02);
    rd("mapper_rd", 8'h42, 8'h77);
    bus.cpu_addr = 16'hD630;
    bus.hyper_cs = 1'b0; bus.cpu_write = 1'b1; bus.hyper_addr = 8'h7F; cyc();
    bus.hyper_addr = 8'h52; bus.hyper_io_data_i = 8'h00; cyc();
    bus.cpu_write = 1'b0; bus.cpu_addr = 16'hD640;
    chk("nocs_mode", {7'b0, bus.hyper_mode}, 8'h01);
    rd("nocs_scratch", 8'h52, 8'hA5);

    // A write while ready is low must not trap.
    wr(8'h7F, 8'h00);
    bus.hyper_cs = 1'b1; bus.cpu_write = 1'b1; bus.ready = 1'b0; bus.hyper_addr = 8'h45;
    cyc();
    bus.hyper_cs = 1'b0; bus.cpu_write = 1'b0; bus.ready = 1'b1;
    chk("noready_mode", {7'b0, bus.hyper_mode}, 8'h00);

    // Reset arriving in the middle of an injection.
    wr(8'h41, 8'h01);
    inj_q.push_back(8'h4C);
    bus.cpu_sync = 1'b1; cyc();
    bus.cpu_sync = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_mid_force", {7'b0, bus.hyper_force_cs}, 8'h00);
    cyc();
    reset = 1'b0;
    chk("rst_mid_mode", {7'b0, bus.hyper_mode}, 8'h00);
    bus.cpu_sync = 1'b1;
    #1;
    chk("rst_mid_pending", {7'b0, bus.hyper_force_cs}, 8'h00);
    bus.cpu_sync = 1'b0;
    rd("rst_mid_trapnum", 8'h44, 8'h00);

`ifdef HYPER_TRAP_COUNT_EN
    for (int i = 0; i < 256; i++) begin
      wr(8'h40, 8'h00);
      wr(8'h7F, 8'h00);
    end
    rd("cnt_wrap", 8'h60, 8'h00);
    wr(8'h40, 8'h00);
    rd("cnt_one", 8'h60, 8'h01);
`else
    wr(8'h40, 8'h00);
    rd("cnt_absent", 8'h60, 8'h00);
`endif

    cyc();
    chk("rd_q_empty",  8'(rd_q.size()),  8'h00);
    chk("inj_q_empty", 8'(inj_q.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
